rv32_icache: RTL and testbench

Parametrised direct-mapped, multi-word-line instruction cache for the RV32I core. It sits between `pcR32I` and the shared single-port zero-delay RAM, and it replaces the single-word fetch buffer. On a miss it stalls the PC and refills a whole line over the RAM port. It adds a flush input for `FENCE.I` and saturating hit/miss counters for performance measurement.

---
 rtl/rv32_icache_pkg.sv | 8 +
 rtl/rv32_icache_store.sv | 42 ++++
 rtl/rv32_icache.sv | 121 ++++++++++++
 tb/tb_rv32_icache.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rv32_icache_pkg.sv
// rv32_icache_pkg: shared types, constants and helpers for the instruction cache
package rv32_icache_pkg;
    typedef enum logic {IDLE, FILL} icache_state_t;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/rv32_icache_store.sv
// rv32_icache_store: valid/tag/data arrays with an async read port and one word write port
module rv32_icache_store #(
    parameter int dataW        = 32,
    parameter int Lines        = 8,
    parameter int WordsPerLine = 4,
    parameter int TagW         = 25
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [$clog2(Lines)-1:0]        i_rd_idx,
    input  logic [$clog2(WordsPerLine)-1:0] i_rd_word,
    output logic                            o_rd_valid,
    output logic [TagW-1:0]                 o_rd_tag,
    output logic [dataW-1:0]                o_rd_data,
    input  logic                            i_we,
    input  logic [$clog2(Lines)-1:0]        i_wr_idx,
    input  logic [$clog2(WordsPerLine)-1:0] i_wr_word,
    input  logic [dataW-1:0]                i_wr_data,
    input  logic                            i_validate,
    input  logic [TagW-1:0]                 i_val_tag,
    input  logic                            i_clear
);
    logic [Lines-1:0] r_valid;
    logic [TagW-1:0]  r_tag  [Lines];
    logic [dataW-1:0] r_data [Lines*WordsPerLine];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_valid <= '0;
        else if (i_clear) r_valid <= '0;
        else if (i_validate) r_valid[i_wr_idx] <= 1'b1;
    end

    // Tags and data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clock) begin
        if (i_validate) r_tag[i_wr_idx] <= i_val_tag;
        if (i_we) r_data[{i_wr_idx, i_wr_word}] <= i_wr_data;
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[{i_rd_idx, i_rd_word}];
endmodule

// File: rtl/rv32_icache.sv
// rv32_icache: direct-mapped multi-word-line instruction cache with line refill,
// FENCE.I flush and saturating hit/miss counters.
module rv32_icache
    import rv32_icache_pkg::*;
#(
    parameter int dataW        = 32,
    parameter int AddrW        = 32,
    parameter int Lines        = 8,
    parameter int WordsPerLine = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AddrW-1:0] ProgAddr,
    input  logic             Flush,
    input  logic [dataW-1:0] InsReadInp,
    output logic [dataW-1:0] OutputIns,
    output logic             InsCacheStall,
    output logic [AddrW-1:0] InsCacheReadAddr,
    output logic [31:0]      HitCount,
    output logic [31:0]      MissCount
);
    localparam int OW = $clog2(WordsPerLine);
    localparam int IW = $clog2(Lines);
    localparam int TW = AddrW - 2 - OW - IW;
    localparam int BW = TW + IW;

    if (Lines < 2 || WordsPerLine < 2 || (Lines & (Lines - 1)) != 0 ||
        (WordsPerLine & (WordsPerLine - 1)) != 0 || dataW != 32) begin : g_bad_params
        $error("rv32_icache: unsupported parameters");
    end

    icache_state_t   r_state, w_next;
    logic [OW-1:0]   r_cnt;
    logic [BW-1:0]   r_fill_base;
    logic [31:0]     r_hit_cnt, r_miss_cnt;

    logic [TW-1:0]   w_tag, w_rd_tag;
    logic [IW-1:0]   w_idx, w_wr_idx;
    logic [OW-1:0]   w_word, w_wr_word;
    logic            w_rd_valid, w_hit, w_miss, w_stall, w_we, w_validate, w_unused;
    logic [dataW-1:0] w_rd_data;

    assign w_tag    = ProgAddr[AddrW-1 -: TW];
    assign w_idx    = ProgAddr[2+OW +: IW];
    assign w_word   = ProgAddr[2 +: OW];
    assign w_unused = ^ProgAddr[1:0];
    assign w_hit    = (r_state == IDLE) && w_rd_valid && (w_rd_tag == w_tag);
    assign w_miss   = (r_state == IDLE) && !w_hit;

    // The miss cycle writes word 0 straight from ProgAddr; FILL cycles use the captured base.
    always_comb begin
        w_next     = r_state;
        w_we       = 1'b0;
        w_wr_idx   = r_fill_base[IW-1:0];
        w_wr_word  = r_cnt;
        w_validate = 1'b0;
        w_stall    = 1'b1;
        if (Flush) begin
            w_next = IDLE;
        end else if (r_state == IDLE) begin
            w_stall = !w_hit;
            if (!w_hit) begin
                w_we      = 1'b1;
                w_wr_idx  = w_idx;
                w_wr_word = '0;
                w_next    = FILL;
            end
        end else begin
            w_we = 1'b1;
            if (r_cnt == OW'(WordsPerLine - 1)) begin
                w_validate = 1'b1;
                w_next     = IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_fill_base <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next == FILL) ? ((r_state == IDLE) ? OW'(1) : r_cnt + OW'(1)) : '0;
            if (!Flush && w_miss) begin
                r_fill_base <= {w_tag, w_idx};
                r_miss_cnt  <= sat_inc32(r_miss_cnt);
            end
            if (!Flush && w_hit) r_hit_cnt <= sat_inc32(r_hit_cnt);
        end
    end

    rv32_icache_store #(
        .dataW(dataW), .Lines(Lines), .WordsPerLine(WordsPerLine), .TagW(TW)
    ) u_store (
        .clock      (clock),
        .reset      (reset),
        .i_rd_idx   (w_idx),
        .i_rd_word  (w_word),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_we),
        .i_wr_idx   (w_wr_idx),
        .i_wr_word  (w_wr_word),
        .i_wr_data  (InsReadInp),
        .i_validate (w_validate),
        .i_val_tag  (r_fill_base[BW-1 -: TW]),
        .i_clear    (Flush)
    );

    assign InsCacheStall    = w_stall || !reset;
    assign OutputIns        = InsCacheStall ? NOP_INSN : w_rd_data;
    assign InsCacheReadAddr = !reset ? '0 :
                              (r_state == FILL) ? {r_fill_base, r_cnt, 2'b00} :
                                                  {w_tag, w_idx, {OW{1'b0}}, 2'b00};
    assign HitCount         = r_hit_cnt;
    assign MissCount        = r_miss_cnt;
endmodule

// File: tb/tb_rv32_icache.sv
// tb_rv32_icache: directed scoreboard bench for rv32_icache (Lines=8, WordsPerLine=4).
module tb_rv32_icache;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock, reset, Flush, InsCacheStall;
    logic [31:0] ProgAddr, InsReadInp, OutputIns, InsCacheReadAddr, HitCount, MissCount;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       tag;
        logic        stall;
        logic [31:0] ins;
        logic [31:0] addr;
        bit          chk_addr;
    } exp_t;
    exp_t sb[$];

    rv32_icache #(.dataW(32), .AddrW(32), .Lines(8), .WordsPerLine(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .ProgAddr         (ProgAddr),
        .Flush            (Flush),
        .InsReadInp       (InsReadInp),
        .OutputIns        (OutputIns),
        .InsCacheStall    (InsCacheStall),
        .InsCacheReadAddr (InsCacheReadAddr),
        .HitCount         (HitCount),
        .MissCount        (MissCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Zero-delay RAM whose contents are a distinct function of each address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    assign InsReadInp = mem(InsCacheStall ? InsCacheReadAddr : ProgAddr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cycle(input string tag, input logic [31:0] pa, input logic fl,
                         input logic st, input logic [31:0] ins,
                         input logic [31:0] ra, input bit ca);
        exp_t e;
        ProgAddr = pa;
        Flush    = fl;
        sb.push_back('{tag, st, ins, ra, ca});
        @(negedge clock);
        e = sb.pop_front();
        chk({e.tag, ".stall"}, {31'd0, InsCacheStall}, {31'd0, e.stall});
        chk({e.tag, ".ins"}, OutputIns, e.ins);
        if (e.chk_addr) chk({e.tag, ".addr"}, InsCacheReadAddr, e.addr);
        @(posedge clock);
        #1;
        Flush = 1'b0;
    endtask

    task automatic refill(input string tag, input logic [31:0] base);
        for (int i = 0; i < 4; i++)
            cycle(tag, base, 1'b0, 1'b1, NOP, base + 32'(4 * i), 1'b1);
    endtask

    task automatic hit(input string tag, input logic [31:0] pa);
        cycle(tag, pa, 1'b0, 1'b0, mem(pa), 32'd0, 1'b0);
    endtask

    initial begin
        reset    = 1'b0;
        Flush    = 1'b0;
        ProgAddr = 32'h100;
        #3;
        chk("rst.stall", {31'd0, InsCacheStall}, 32'd1);
        chk("rst.ins", OutputIns, NOP);
        chk("rst.addr", InsCacheReadAddr, 32'd0);
        chk("rst.hit", HitCount, 32'd0);
        chk("rst.miss", MissCount, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        refill("cold", 32'h100);
        hit("cold.hit", 32'h100);
        chk("cold.miss_cnt", MissCount, 32'd1);
        chk("cold.hit_cnt", HitCount, 32'd1);

        hit("seq.104", 32'h104);
        hit("seq.108", 32'h108);
        hit("seq.10c", 32'h10C);
        chk("seq.hit_cnt", HitCount, 32'd4);

        refill("evict.180", 32'h180);
        hit("evict.hit180", 32'h180);
        refill("evict.back100", 32'h100);
        chk("evict.miss_cnt", MissCount, 32'd3);
        hit("evict.hit100", 32'h100);
        chk("evict.hit_cnt", HitCount, 32'd6);

        cycle("flush", 32'h100, 1'b1, 1'b1, NOP, 32'd0, 1'b0);
        chk("flush.hit_cnt", HitCount, 32'd6);
        chk("flush.miss_cnt", MissCount, 32'd3);
        refill("flush.remiss", 32'h100);
        chk("flush.remiss_cnt", MissCount, 32'd4);
        hit("flush.hit", 32'h100);

        cycle("ffill.c0", 32'h200, 1'b0, 1'b1, NOP, 32'h200, 1'b1);
        cycle("ffill.c1", 32'h200, 1'b1, 1'b1, NOP, 32'h204, 1'b1);
        chk("ffill.miss_cnt", MissCount, 32'd5);
        refill("ffill.remiss", 32'h200);
        chk("ffill.remiss_cnt", MissCount, 32'd6);
        hit("ffill.hit", 32'h20C);
        chk("ffill.hit_cnt", HitCount, 32'd8);

        cycle("arst.c0", 32'h300, 1'b0, 1'b1, NOP, 32'h300, 1'b1);
        cycle("arst.c1", 32'h300, 1'b0, 1'b1, NOP, 32'h304, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("arst.stall", {31'd0, InsCacheStall}, 32'd1);
        chk("arst.ins", OutputIns, NOP);
        chk("arst.addr", InsCacheReadAddr, 32'd0);
        chk("arst.hit", HitCount, 32'd0);
        chk("arst.miss", MissCount, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        refill("arst.cold", 32'h100);
        chk("arst.cold_miss", MissCount, 32'd1);
        hit("arst.hit", 32'h108);

        force dut.r_miss_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_miss_cnt;
        chk("sat.preset", MissCount, 32'hFFFF_FFFF);
        cycle("sat.miss", 32'h140, 1'b0, 1'b1, NOP, 32'h140, 1'b1);
        chk("sat.miss_cnt", MissCount, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
